// File: rtl/ones_generator.sv
// Ones generator: builds an R1_size-bit word holding `count` contiguous ones via a
// one-hot controller and shift/decrement datapath. Define ONES_GEN_MSB_FILL_EN to pack from the MSB.
module ones_generator #(
  parameter int unsigned R1_size = 8,
  parameter int unsigned R2_size = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Start,
  input  logic [R2_size-1:0] count,
  output logic [R1_size-1:0] data,
  output logic               Ready,
  output logic               Sat
);

  localparam logic [R2_size-1:0] R1_MAX = R2_size'(R1_size);

  typedef enum logic [2:0] {
    S_idle = 3'b001,
    S_1    = 3'b010,
    S_2    = 3'b100
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               load;
  logic               shift;
  logic               decr;
  logic               zero;
  logic [R1_size-1:0] r1;
  logic [R2_size-1:0] r2;
  logic               sat_q;
  logic [R1_size-1:0] r1_filled;

  assign zero  = (r2 == '0);
  assign data  = r1;
  assign Sat   = sat_q;

`ifdef ONES_GEN_MSB_FILL_EN
  assign r1_filled = {1'b1, r1[R1_size-1:1]};
`else
  assign r1_filled = {r1[R1_size-2:0], 1'b1};
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_idle;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    decr       = 1'b0;
    Ready      = 1'b0;
    case (state)
      S_idle: begin
        Ready = 1'b1;
        if (Start) begin
          load       = 1'b1;
          next_state = S_1;
        end
      end
      S_1: begin
        if (zero) begin
          next_state = S_idle;
        end else begin
          shift      = 1'b1;
          next_state = S_2;
        end
      end
      S_2: begin
        decr       = 1'b1;
        next_state = S_1;
      end
      default: next_state = S_idle;
    endcase
  end

  // Datapath: count is clamped to the word width on load, Sat flags the clamp
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1    <= '0;
      r2    <= '0;
      sat_q <= 1'b0;
    end else if (load) begin
      r1    <= '0;
      r2    <= (count > R1_MAX) ? R1_MAX : count;
      sat_q <= (count > R1_MAX);
    end else if (shift) begin
      r1    <= r1_filled;
    end else if (decr) begin
      r2    <= r2 - R2_size'(1);
    end
  end

endmodule

// File: tb/tb_ones_generator.sv
// Scoreboard bench for ones_generator: driver queues expected results, a monitor
// checks each completed run when Ready rises.
module tb_ones_generator;

  logic       clock;
  logic       reset;
  logic       Start;
  logic [3:0] count;
  logic [7:0] data;
  logic       Ready;
  logic       Sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       sat;
    int         lat;   // -1: run aborted by reset, latency not checked
    int         ones;
  } exp_t;

  exp_t sb[$];

  ones_generator #(.R1_size(8), .R2_size(4)) dut (
    .clock(clock), .reset(reset), .Start(Start), .count(count),
    .data(data), .Ready(Ready), .Sat(Sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per Ready rising edge
  logic prev_ready = 1'b1;
  int   low_cnt    = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!Ready) begin
      low_cnt++;
    end else if (!prev_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(data), 32'(e.data));
        chk("sat", 32'(Sat), 32'(e.sat));
        chk("popcount", 32'($countones(data)), 32'(e.ones));
        if (e.lat >= 0) chk("latency", 32'(low_cnt), 32'(e.lat));
      end
      low_cnt = 0;
    end
    prev_ready = Ready;
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (Ready !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (Ready !== 1'b1) chk("ready_timeout", 32'(Ready), 32'd1);
  endtask

  task automatic push(input logic [7:0] lsb_d, input logic [7:0] msb_d,
                      input logic s, input int lat, input int ones);
    exp_t e;
`ifdef ONES_GEN_MSB_FILL_EN
    e.data = msb_d;
`else
    e.data = lsb_d;
`endif
    e.sat  = s;
    e.lat  = lat;
    e.ones = ones;
    sb.push_back(e);
  endtask

  // Issue one run with a single-cycle Start pulse
  task automatic run(input logic [3:0] c, input logic [7:0] lsb_d, input logic [7:0] msb_d,
                     input logic s, input int lat, input int ones);
    wait_ready(50);
    count = c;
    Start = 1'b1;
    push(lsb_d, msb_d, s, lat, ones);
    @(negedge clock);
    Start = 1'b0;
    @(negedge clock);
    wait_ready(50);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    Start = 1'b0;
    count = '0;
    #3 reset = 1'b1;
    @(negedge clock);
    chk("reset_ready", 32'(Ready), 32'd1);
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_sat", 32'(Sat), 32'd0);
    chk("reset_state", 32'(dut.state), 32'b001);

    run(4'd3,  8'h07, 8'hE0, 1'b0, 7,  3);
    run(4'd0,  8'h00, 8'h00, 1'b0, 1,  0);
    run(4'd8,  8'hFF, 8'hFF, 1'b0, 17, 8);
    run(4'd12, 8'hFF, 8'hFF, 1'b1, 17, 8);
    run(4'd1,  8'h01, 8'h80, 1'b0, 3,  1);

    // Start and count changes while busy are ignored
    wait_ready(50);
    count = 4'd5;
    Start = 1'b1;
    push(8'h1F, 8'hF8, 1'b0, 11, 5);
    @(negedge clock);
    Start = 1'b0;
    @(negedge clock);
    count = 4'd1;
    Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    wait_ready(50);
    @(negedge clock);

    // Start held high: back-to-back reload, first result visible one cycle
    count = 4'd2;
    Start = 1'b1;
    push(8'h03, 8'hC0, 1'b0, 5, 2);
    push(8'h0F, 8'hF0, 1'b0, 9, 4);
    @(negedge clock);
    count = 4'd4;
    wait_ready(50);
    @(negedge clock);
    Start = 1'b0;
    wait_ready(50);
    @(negedge clock);

    // Reset mid-run aborts immediately and clears Sat
    count = 4'd12;
    Start = 1'b1;
    push(8'h00, 8'h00, 1'b0, -1, 0);
    @(negedge clock);
    Start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(Ready), 32'd1);
    chk("abort_data", 32'(data), 32'h00);
    chk("abort_sat", 32'(Sat), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run(4'd6, 8'h3F, 8'hFC, 1'b0, 13, 6);

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_generator.md
Name: ones_generator

Overview:
- Inverse of the team's ones counter: accepts a population count and serially builds an R1_size-bit word containing exactly that many ones, packed contiguously from the LSB.
- Uses the same Start/Ready handshake and controller/datapath split: one-hot controller plus shift/decrement datapath.
- Used to produce masks and test vectors, and to round-trip check the ones counter.

Parameters:
- R1_size, 8, width of the generated word (R1 shift register).
- R2_size, 4, width of the count input and the R2 down-counter; constraint 2**R2_size - 1 >= R1_size.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only while Ready=1.
- count  input  R2_size  number of ones requested; sampled on the load edge.
- data  output  R1_size  generated word (R1); valid whenever Ready=1 after a completed run.
- Ready  output  1  high in S_idle (combinational from state).
- Sat  output  1  registered; set when the loaded count exceeded R1_size.

Behaviour:
- States, one-hot: S_idle=3'b001, S_1=3'b010, S_2=3'b100.
- Reset (async, reset==0): state=S_idle, R1=0, R2=0, Sat=0. Ready=1 once reset is applied. Reset mid-run aborts to these values immediately.
- S_idle:
  - Ready=1.
  - If Start=1: Load asserted. On the edge, R1<=0, R2<=min(count, R1_size), Sat<=(count>R1_size), next=S_1.
  - Otherwise stay in S_idle; R1, R2 and Sat hold.
- S_1:
  - Ready=0. Zero=(R2==0).
  - If Zero: next=S_idle.
  - Else: Shift asserted, R1<={R1[R1_size-2:0],1'b1}, next=S_2.
- S_2:
  - Ready=0. Decr asserted, R2<=R2-1, next=S_1.
- Latency: for a clamped count n, Ready returns high exactly 2n+1 clock edges after the load edge.
  - n=0 gives 1 cycle; n=8 gives 17 cycles.
- Result: data = (1<<n)-1 when Ready rises; it holds until the next load or reset.
- Start while busy (S_1/S_2): ignored; count changes mid-run have no effect.
- Start held high continuously: a new load occurs on the first S_idle cycle. data is then visible for only one cycle and is reset to 0 on that load edge.
  - Callers wanting a stable result must drop Start before completion.
- No underflow: R2 is never decremented at 0, because S_2 is only entered when R2!=0.
- Shift and Decr are never asserted in the same cycle; Load is never asserted outside S_idle.
- Illegal/unused state encodings: next=S_idle.

Optional Feature:
- Macro ONES_GEN_MSB_FILL_EN.
- Defined: S_1 shift becomes R1<={1'b1,R1[R1_size-1:1]}, so ones pack from the MSB; the result is ~((1<<(R1_size-n))-1). Latency, Sat and the handshake are unchanged.
- Undefined: LSB fill as specified above.

Test Plan:
- reset=0 for 3ns, then 1; no Start -> Ready=1, data=8'h00, Sat=0, state=3'b001.
- count=3, Start pulsed for 1 cycle -> Ready low for 7 cycles, then data=8'b0000_0111, Sat=0.
- count=0 -> Ready low for exactly 1 cycle, data=8'h00.
- count=8 -> data=8'hFF after 17 cycles, Sat=0. count=12 -> data=8'hFF after 17 cycles, Sat=1.
- count=5, Start; then change count to 1 and pulse Start during S_2 -> both ignored, data=8'h1F. Then assert reset=0 mid-run on a second run -> data=0, Ready=1 immediately.
- With ONES_GEN_MSB_FILL_EN defined: count=3 -> data=8'b1110_0000 after 7 cycles. Feed the result into Ones_Counter -> count=3.
